// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues variable-latency instruction
// memory requests, parks a returned word while the pipeline is stalled, and
// drives the IF/ID pipeline register consumed by the decode stage.
module if_fetch_unit #(
    parameter int unsigned            ADDR_W   = 32,
    parameter int unsigned            DATA_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0,
    parameter logic [ADDR_W-1:0]      PC_INC   = ADDR_W'(4),
    parameter logic [DATA_W-1:0]      NOP_INS  = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] BRANCH_TARGET,
    input  logic              PC_SRC,
    input  logic              STALL,
    input  logic              FLUSH,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [DATA_W-1:0] IMEM_RDATA,
    input  logic              IMEM_VALID,
    output logic [ADDR_W-1:0] NEXT_INS_ADR_OUT,
    output logic [DATA_W-1:0] CUR_INS_OUT,
    output logic              IF_ID_VALID
);

    // IDLE is a one-cycle request gap, FETCH has a request outstanding,
    // HOLD parks a returned word until the stall clears.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              r_redir_pend;
    logic              w_redir_pend_nxt;
    logic [ADDR_W-1:0] r_redir_addr;
    logic [ADDR_W-1:0] w_redir_addr_nxt;
    logic [DATA_W-1:0] r_hold_data;
    logic [DATA_W-1:0] w_hold_data_nxt;
    logic              w_deliver;
    logic [DATA_W-1:0] w_deliver_data;

    logic [ADDR_W-1:0] r_ifid_next_adr;
    logic [DATA_W-1:0] r_ifid_ins;
    logic              r_ifid_valid;

    // Sequential successor; wraps modulo 2^ADDR_W.
    assign w_pc_inc = r_pc + PC_INC;

    // Next-state, next-PC, redirect bookkeeping and delivery decision.
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_addr_nxt = r_redir_addr;
        w_hold_data_nxt  = r_hold_data;
        w_deliver        = 1'b0;
        w_deliver_data   = IMEM_RDATA;

        unique case (r_state)
            ST_IDLE: begin
                // A late IMEM_VALID here belongs to an abandoned request.
                w_state_nxt = ST_FETCH;
                if (PC_SRC) begin
                    w_pc_nxt = BRANCH_TARGET;
                end
            end

            ST_FETCH: begin
                if (!IMEM_VALID) begin
                    // The address must stay stable until the memory answers,
                    // so a redirect is remembered rather than applied.
                    if (PC_SRC) begin
                        w_redir_pend_nxt = 1'b1;
                        w_redir_addr_nxt = BRANCH_TARGET;
                    end
                end else if (PC_SRC || r_redir_pend) begin
                    // Returned word is on the wrong path: drop it.
                    w_pc_nxt         = PC_SRC ? BRANCH_TARGET : r_redir_addr;
                    w_redir_pend_nxt = 1'b0;
                    w_state_nxt      = ST_IDLE;
                end else if (!STALL) begin
                    w_deliver = 1'b1;
                    w_pc_nxt  = w_pc_inc;
                end else begin
                    w_hold_data_nxt = IMEM_RDATA;
                    w_state_nxt     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                w_deliver_data = r_hold_data;
                if (STALL) begin
                    w_state_nxt = ST_HOLD;
                end else if (PC_SRC) begin
                    w_pc_nxt    = BRANCH_TARGET;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_deliver   = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch-side state: FSM, PC, pending redirect and holding buffer.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_addr <= '0;
            r_hold_data  <= NOP_INS;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_addr <= w_redir_addr_nxt;
            r_hold_data  <= w_hold_data_nxt;
        end
    end

    // IF/ID register: flush beats stall beats delivery beats bubble.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ifid_next_adr <= '0;
            r_ifid_ins      <= NOP_INS;
            r_ifid_valid    <= 1'b0;
        end else if (FLUSH) begin
            r_ifid_ins   <= NOP_INS;
            r_ifid_valid <= 1'b0;
        end else if (STALL) begin
            r_ifid_valid <= r_ifid_valid;
        end else if (w_deliver) begin
            r_ifid_next_adr <= w_pc_inc;
            r_ifid_ins      <= w_deliver_data;
            r_ifid_valid    <= 1'b1;
        end else begin
            r_ifid_ins   <= NOP_INS;
            r_ifid_valid <= 1'b0;
        end
    end

    assign IMEM_REQ         = (r_state == ST_FETCH);
    assign IMEM_ADDR        = r_pc;
    assign NEXT_INS_ADR_OUT = r_ifid_next_adr;
    assign CUR_INS_OUT      = r_ifid_ins;
    assign IF_ID_VALID      = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a latency-programmable instruction memory, a
// transaction-level reference model compared every cycle, and directed
// scenarios with hand-computed expectations.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] MEM_BASE = 32'h1000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic        PC_SRC = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA = '0;
    logic        IMEM_VALID = 1'b0;
    logic [31:0] NEXT_INS_ADR_OUT;
    logic [31:0] CUR_INS_OUT;
    logic        IF_ID_VALID;

    int n_checks = 0;
    int n_fail = 0;
    int lat = 1;
    int mem_cnt = 0;

    if_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0),
        .PC_INC  (32'd4),
        .NOP_INS (NOP)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .BRANCH_TARGET   (BRANCH_TARGET),
        .PC_SRC          (PC_SRC),
        .STALL           (STALL),
        .FLUSH           (FLUSH),
        .IMEM_REQ        (IMEM_REQ),
        .IMEM_ADDR       (IMEM_ADDR),
        .IMEM_RDATA      (IMEM_RDATA),
        .IMEM_VALID      (IMEM_VALID),
        .NEXT_INS_ADR_OUT(NEXT_INS_ADR_OUT),
        .CUR_INS_OUT     (CUR_INS_OUT),
        .IF_ID_VALID     (IF_ID_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: answers a request after 'lat' cycles with MEM_BASE + address.
    always @(negedge CLK) begin
        if (!RST_N) begin
            mem_cnt    = 0;
            IMEM_VALID = 1'b0;
        end else if (IMEM_REQ) begin
            if (mem_cnt >= lat - 1) begin
                IMEM_VALID = 1'b1;
                IMEM_RDATA = MEM_BASE + IMEM_ADDR;
                mem_cnt    = 0;
            end else begin
                IMEM_VALID = 1'b0;
                mem_cnt++;
            end
        end else begin
            IMEM_VALID = 1'b0;
            mem_cnt    = 0;
        end
    end

    // Reference model: request outstanding flag, parked-word queue and
    // pending-redirect queue describe the fetch side; IF/ID follows the
    // flush/stall/deliver/bubble priority.
    logic [31:0] m_pc = 32'h0;
    bit          m_req = 1'b0;
    logic [31:0] m_buf[$];
    logic [31:0] m_redir[$];
    logic [31:0] m_nxt = 32'h0;
    logic [31:0] m_ins = NOP;
    bit          m_vld = 1'b0;

    always @(posedge CLK) begin : model
        bit          del;
        logic [31:0] dw;
        logic [31:0] seq;
        del = 1'b0;
        dw  = '0;
        seq = m_pc + 32'd4;
        if (!RST_N) begin
            m_pc  = 32'h0;
            m_req = 1'b0;
            m_buf.delete();
            m_redir.delete();
            m_nxt = 32'h0;
            m_ins = NOP;
            m_vld = 1'b0;
        end else begin
            if (m_buf.size() != 0) begin
                if (!STALL) begin
                    if (PC_SRC) begin
                        m_buf.delete();
                        m_pc = BRANCH_TARGET;
                    end else begin
                        del   = 1'b1;
                        dw    = m_buf.pop_front();
                        m_pc  = seq;
                        m_req = 1'b1;
                    end
                end
            end else if (!m_req) begin
                if (PC_SRC) m_pc = BRANCH_TARGET;
                m_req = 1'b1;
            end else if (!IMEM_VALID) begin
                if (PC_SRC) begin
                    m_redir.delete();
                    m_redir.push_back(BRANCH_TARGET);
                end
            end else if (PC_SRC || m_redir.size() != 0) begin
                m_pc = PC_SRC ? BRANCH_TARGET : m_redir[0];
                m_redir.delete();
                m_req = 1'b0;
            end else if (!STALL) begin
                del  = 1'b1;
                dw   = IMEM_RDATA;
                m_pc = seq;
            end else begin
                m_buf.push_back(IMEM_RDATA);
                m_req = 1'b0;
            end

            if (FLUSH) begin
                m_ins = NOP;
                m_vld = 1'b0;
            end else if (!STALL) begin
                if (del) begin
                    m_nxt = seq;
                    m_ins = dw;
                    m_vld = 1'b1;
                end else begin
                    m_ins = NOP;
                    m_vld = 1'b0;
                end
            end
        end
        #1;
        check("model_req",   {31'b0, IMEM_REQ},    {31'b0, m_req});
        check("model_addr",  IMEM_ADDR,            m_pc);
        check("model_next",  NEXT_INS_ADR_OUT,     m_nxt);
        check("model_ins",   CUR_INS_OUT,          m_ins);
        check("model_valid", {31'b0, IF_ID_VALID}, {31'b0, m_vld});
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic expect_ifid(input string tag, input logic vld, input logic [31:0] ins,
                               input logic [31:0] nxt);
        check({tag, "_valid"}, {31'b0, IF_ID_VALID}, {31'b0, vld});
        check({tag, "_ins"},   CUR_INS_OUT,          ins);
        check({tag, "_next"},  NEXT_INS_ADR_OUT,     nxt);
    endtask

    task automatic expect_fetch(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"},  {31'b0, IMEM_REQ}, {31'b0, req});
        check({tag, "_addr"}, IMEM_ADDR,         addr);
    endtask

    // Stall/flush/redirect vectors: {stall, flush, pc_src, target}.
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        pc_src;
        logic [31:0] target;
    } vec_t;

    vec_t vecs[20] = '{
        '{1'b0, 1'b0, 1'b0, 32'h0},   '{1'b1, 1'b0, 1'b0, 32'h0},
        '{1'b1, 1'b0, 1'b0, 32'h0},   '{1'b0, 1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b1, 1'b1, 32'h100}, '{1'b0, 1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b0, 1'b0, 32'h0},   '{1'b1, 1'b0, 1'b0, 32'h0},
        '{1'b1, 1'b0, 1'b0, 32'h0},   '{1'b0, 1'b1, 1'b1, 32'h200},
        '{1'b0, 1'b0, 1'b0, 32'h0},   '{1'b0, 1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b1, 1'b1, 32'h300}, '{1'b0, 1'b1, 1'b1, 32'h304},
        '{1'b0, 1'b0, 1'b0, 32'h0},   '{1'b0, 1'b0, 1'b0, 32'h0},
        '{1'b1, 1'b0, 1'b0, 32'h0},   '{1'b0, 1'b0, 1'b0, 32'h0},
        '{1'b1, 1'b1, 1'b0, 32'h0},   '{1'b0, 1'b0, 1'b0, 32'h0}
    };

    initial begin
        // Reset values.
        @(negedge CLK);
        @(negedge CLK);
        expect_fetch("rst", 1'b0, 32'h0);
        expect_ifid("rst", 1'b0, NOP, 32'h0);

        // Zero-wait memory sustains one instruction per cycle.
        RST_N = 1'b1;
        tick();
        expect_fetch("zw_c1", 1'b1, 32'h0);
        expect_ifid("zw_c1", 1'b0, NOP, 32'h0);
        tick();
        expect_fetch("zw_c2", 1'b1, 32'h4);
        expect_ifid("zw_c2", 1'b1, 32'h1000_0000, 32'h4);
        tick();
        expect_fetch("zw_c3", 1'b1, 32'h8);
        expect_ifid("zw_c3", 1'b1, 32'h1000_0004, 32'h8);

        // Three-cycle memory: request held at a stable address, bubbles between.
        lat = 3;
        tick();
        expect_fetch("l3_c1", 1'b1, 32'h8);
        expect_ifid("l3_c1", 1'b0, NOP, 32'h8);
        tick();
        expect_fetch("l3_c2", 1'b1, 32'h8);
        expect_ifid("l3_c2", 1'b0, NOP, 32'h8);
        tick();
        expect_fetch("l3_c3", 1'b1, 32'hC);
        expect_ifid("l3_c3", 1'b1, 32'h1000_0008, 32'hC);

        // Redirect one cycle into a request: returned word discarded.
        PC_SRC = 1'b1;
        FLUSH = 1'b1;
        BRANCH_TARGET = 32'h40;
        tick();
        PC_SRC = 1'b0;
        FLUSH = 1'b0;
        expect_fetch("br_c1", 1'b1, 32'hC);
        expect_ifid("br_c1", 1'b0, NOP, 32'hC);
        tick();
        expect_fetch("br_c2", 1'b1, 32'hC);
        tick();
        expect_fetch("br_gap", 1'b0, 32'h40);
        expect_ifid("br_gap", 1'b0, NOP, 32'hC);
        tick();
        expect_fetch("br_new", 1'b1, 32'h40);

        // Stall for four cycles spanning the memory response.
        tick();
        STALL = 1'b1;
        tick();
        expect_fetch("st_c1", 1'b1, 32'h40);
        tick();
        expect_fetch("st_hold", 1'b0, 32'h40);
        expect_ifid("st_hold", 1'b0, NOP, 32'hC);
        tick();
        tick();
        expect_fetch("st_c4", 1'b0, 32'h40);
        STALL = 1'b0;
        tick();
        expect_fetch("st_rel", 1'b1, 32'h44);
        expect_ifid("st_rel", 1'b1, 32'h1000_0040, 32'h44);
        tick();
        expect_ifid("st_nodup", 1'b0, NOP, 32'h44);

        // Back to zero-wait; then flush+stall with a redirect to the top page.
        lat = 1;
        tick();
        expect_ifid("zw2", 1'b1, 32'h1000_0044, 32'h48);
        STALL = 1'b1;
        FLUSH = 1'b1;
        PC_SRC = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        tick();
        STALL = 1'b0;
        FLUSH = 1'b0;
        PC_SRC = 1'b0;
        expect_ifid("fl", 1'b0, NOP, 32'h48);
        expect_fetch("fl", 1'b0, 32'hFFFF_FFFC);
        tick();
        expect_fetch("wrap_req", 1'b1, 32'hFFFF_FFFC);
        tick();
        expect_fetch("wrap", 1'b1, 32'h0);
        expect_ifid("wrap", 1'b1, 32'h0FFF_FFFC, 32'h0);
        tick();
        expect_ifid("pre_rst", 1'b1, 32'h1000_0000, 32'h4);

        // Asynchronous reset between edges, mid-fetch.
        #1;
        RST_N = 1'b0;
        #1;
        expect_fetch("arst", 1'b0, 32'h0);
        expect_ifid("arst", 1'b0, NOP, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        expect_fetch("rst_rel", 1'b1, 32'h0);
        tick();
        expect_ifid("rst_rel", 1'b1, 32'h1000_0000, 32'h4);

        // Mixed stall/flush/redirect vectors, checked by the model.
        lat = 2;
        foreach (vecs[i]) begin
            STALL         = vecs[i].stall;
            FLUSH         = vecs[i].flush;
            PC_SRC        = vecs[i].pc_src;
            BRANCH_TARGET = vecs[i].target;
            tick();
        end
        STALL = 1'b0;
        FLUSH = 1'b0;
        PC_SRC = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 100000);
        $fatal(1, "watchdog expired");
    end

endmodule
